// File: rtl/bram_port_ctrl_pkg.sv
// bram_port_ctrl_pkg
// Shared types and constants for the BRAM port controller and its response FIFO.

package bram_port_ctrl_pkg;

    // Controller FSM: INIT clears the BRAM after reset, RUN serves requests.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    // Number of read responses that may be buffered or in flight at once.
    localparam int RSP_DEPTH = 3;

endpackage

// File: rtl/bram_port_ctrl_rsp_fifo.sv
// rsp_fifo
// Small synchronous FIFO that holds read data until the consumer takes it.
// Push to a full FIFO and pop from an empty FIFO are ignored.

module rsp_fifo #(
    parameter  int Width = 36,
    parameter  int Depth = 3,
    localparam int CW    = $clog2(Depth + 1),
    localparam int PW    = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(Depth));
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(Depth - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(Depth - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_port_ctrl.sv
// bram_port_ctrl
// Valid/ready front-end for a single-port, read-first, 1-cycle-latency BRAM.
// Reads return in order through a small response FIFO with backpressure.
// Optional feature: define BRAM_PORT_CTRL_INIT_EN to zero every BRAM word
// after each reset before any request is accepted.

module bram_port_ctrl
    import bram_port_ctrl_pkg::*;
#(
    parameter  int Depth = 512,
    parameter  int Width = 36,
    localparam int AW    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wen,
    input  logic [AW-1:0]    req_addr,
    input  logic [Width-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [Width-1:0] rsp_rdata,
    output logic             busy,
    output logic             bram_en,
    output logic             bram_wen,
    output logic [AW-1:0]    bram_addr,
    output logic [Width-1:0] bram_din,
    input  logic [Width-1:0] bram_dout
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          sweep_active;
    logic [AW-1:0] sweep_addr;
    logic          rd_inflight;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [CW:0]   occ;
    logic          accept;

`ifdef BRAM_PORT_CTRL_INIT_EN
    ctrl_state_e   state;
    logic [AW-1:0] clr_addr;
    logic          busy_q;

    // Sweep FSM: one zero write per cycle from 0 to Depth-1, then serve traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            clr_addr <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == AW'(Depth - 1)) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    clr_addr <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_active = (state == INIT);
    assign sweep_addr   = clr_addr;
    assign busy         = busy_q;
`else
    assign sweep_active = 1'b0;
    assign sweep_addr   = '0;
    assign busy         = 1'b0;
`endif

    // Occupancy only counts registered state, so req_ready never depends
    // on rsp_ready or req_valid in the same cycle.
    assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight};
    assign req_ready = !rst && !sweep_active && (occ < (CW + 1)'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !fifo_empty;

    // BRAM strobes: sweep writes take priority, otherwise forward an accepted request.
    always_comb begin
        bram_en   = 1'b0;
        bram_wen  = 1'b0;
        bram_addr = req_addr;
        bram_din  = req_wdata;
        if (!rst && sweep_active) begin
            bram_en   = 1'b1;
            bram_wen  = 1'b1;
            bram_addr = sweep_addr;
            bram_din  = '0;
        end else if (accept) begin
            bram_en  = 1'b1;
            bram_wen = req_wen;
        end
    end

    // A read issued this cycle lands in the FIFO on the next clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= accept && !req_wen;
        end
    end

    rsp_fifo #(
        .Width (Width),
        .Depth (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_inflight),
        .din   (bram_dout),
        .pop   (rsp_valid && rsp_ready),
        .dout  (rsp_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_bram_port_ctrl.sv
// tb_bram_port_ctrl
// Directed self-checking bench for bram_port_ctrl with a small read-first BRAM
// model. Follows BRAM_PORT_CTRL_INIT_EN the same way the design does.

module tb_bram_port_ctrl;

    localparam int Depth = 16;
    localparam int Width = 36;
    localparam int AW    = $clog2(Depth);

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_wen;
    logic [AW-1:0]    req_addr;
    logic [Width-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [Width-1:0] rsp_rdata;
    logic             busy;
    logic             bram_en;
    logic             bram_wen;
    logic [AW-1:0]    bram_addr;
    logic [Width-1:0] bram_din;
    logic [Width-1:0] bram_dout;

    logic [Width-1:0] mem [Depth];

    int errors = 0;
    int checks = 0;

`ifdef BRAM_PORT_CTRL_INIT_EN
    localparam bit Sweep = 1'b1;
`else
    localparam bit Sweep = 1'b0;
`endif

    bram_port_ctrl #(
        .Depth (Depth),
        .Width (Width)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .bram_en   (bram_en),
        .bram_wen  (bram_wen),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port BRAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (bram_en) begin
            bram_dout <= mem[bram_addr];
            if (bram_wen) mem[bram_addr] <= bram_din;
        end
    end

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < Depth; i++) mem[i] = Width'(36'h100 + i);
        bram_dout = '0;
        apply_reset();
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || bram_en !== 1'b0 || bram_wen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b en=%b wen=%b, expected all 0",
                     req_ready, rsp_valid, bram_en, bram_wen);
        end
        checks++;
        if (busy !== Sweep) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected %b", busy, Sweep);
        end
        @(negedge clk);
        rst = 1'b0;
        if (Sweep) begin
            for (int i = 0; i < Depth; i++) begin
                #1;
                checks++;
                if (busy !== 1'b1 || req_ready !== 1'b0 || bram_en !== 1'b1 || bram_wen !== 1'b1 ||
                    bram_addr !== AW'(i) || bram_din !== '0) begin
                    errors++;
                    $display("[TB] FAIL sweep_cycle%0d: got busy=%b rdy=%b en=%b wen=%b addr=%0d din=%h, expected busy=1 rdy=0 en=1 wen=1 addr=%0d din=0",
                             i, busy, req_ready, bram_en, bram_wen, bram_addr, bram_din, i);
                end
                @(negedge clk);
            end
        end
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got busy=%b rdy=%b expected busy=0 rdy=1", busy, req_ready);
        end
        @(negedge clk);
        // Read address 5: zero after a sweep, original contents otherwise.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 4'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== (Sweep ? 36'h0 : 36'h105)) begin
            errors++;
            $display("[TB] FAIL read_addr5: got vld=%b data=%h expected vld=1 data=%h",
                     rsp_valid, rsp_rdata, Sweep ? 36'h0 : 36'h105);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 4'd7; req_wdata = 36'h0_ABCD_1234;
        #1;
        checks++;
        if (req_ready !== 1'b1 || bram_en !== 1'b1 || bram_wen !== 1'b1 ||
            bram_addr !== 4'd7 || bram_din !== 36'h0_ABCD_1234) begin
            errors++;
            $display("[TB] FAIL write_strobes: got rdy=%b en=%b wen=%b addr=%0d din=%h expected 1 1 1 7 0abcd1234",
                     req_ready, bram_en, bram_wen, bram_addr, bram_din);
        end
        @(negedge clk);
        req_wen = 1'b0; req_wdata = '0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || bram_en !== 1'b1 || bram_wen !== 1'b0 || bram_addr !== 4'd7) begin
            errors++;
            $display("[TB] FAIL read_strobes: got rdy=%b en=%b wen=%b addr=%0d expected 1 1 0 7",
                     req_ready, bram_en, bram_wen, bram_addr);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || bram_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rsp_too_early: got vld=%b en=%b expected 0 0", rsp_valid, bram_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 36'h0_ABCD_1234) begin
            errors++;
            $display("[TB] FAIL raw_data: got vld=%b data=%h expected 1 0abcd1234", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raw_popped: got vld=%b expected 0", rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_wen = 1'b1; req_addr = AW'(i); req_wdata = Width'(i * 3);
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL preload_ready%0d: got %b expected 1", i, req_ready);
            end
            @(negedge clk);
        end
        req_wen = 1'b0; req_wdata = '0;
        for (int t = 0; t < 11; t++) begin
            req_valid = (t < 8);
            req_addr  = AW'(t < 8 ? t : 0);
            #1;
            if (t < 8) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stream_ready%0d: got %b expected 1", t, req_ready);
                end
            end
            checks++;
            if (t >= 2 && t < 10) begin
                if (rsp_valid !== 1'b1 || rsp_rdata !== Width'((t - 2) * 3)) begin
                    errors++;
                    $display("[TB] FAIL stream_rsp%0d: got vld=%b data=%h expected vld=1 data=%h",
                             t, rsp_valid, rsp_rdata, Width'((t - 2) * 3));
                end
            end else if (rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stream_idle%0d: got vld=%b expected 0", t, rsp_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rsp_ready = 1'b0;
        req_wen   = 1'b0;
        for (int t = 0; t < 5; t++) begin
            req_valid = 1'b1;
            req_addr  = AW'(t < 3 ? t + 1 : 4);
            #1;
            checks++;
            if (req_ready !== exp_rdy[t] || bram_en !== exp_rdy[t]) begin
                errors++;
                $display("[TB] FAIL bp_ready%0d: got rdy=%b en=%b expected %b", t, req_ready, bram_en, exp_rdy[t]);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #1;
            checks++;
            if (t < 3) begin
                if (rsp_valid !== 1'b1 || rsp_rdata !== Width'((t + 1) * 3)) begin
                    errors++;
                    $display("[TB] FAIL bp_rsp%0d: got vld=%b data=%h expected vld=1 data=%h",
                             t, rsp_valid, rsp_rdata, Width'((t + 1) * 3));
                end
            end else if (rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_drained: got vld=%b expected 0", rsp_valid);
            end
            checks++;
            if (req_ready !== (t != 0)) begin
                errors++;
                $display("[TB] FAIL bp_ready_return%0d: got %b expected %b", t, req_ready, (t != 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_traffic();
        int stale = 0;
        rsp_ready = 1'b0;
        req_wen   = 1'b0;
        for (int t = 0; t < 2; t++) begin
            req_valid = 1'b1;
            req_addr  = AW'(t + 1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pending: got vld=%b expected 1", rsp_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || bram_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_clear: got vld=%b rdy=%b en=%b expected 0 0 0",
                     rsp_valid, req_ready, bram_en);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (busy !== Sweep || bram_en !== Sweep || bram_addr !== (Sweep ? 4'd0 : bram_addr) ||
            req_ready !== !Sweep) begin
            errors++;
            $display("[TB] FAIL restart: got busy=%b en=%b addr=%0d rdy=%b expected busy=%b en=%b addr=0 rdy=%b",
                     busy, bram_en, bram_addr, req_ready, Sweep, Sweep, !Sweep);
        end
        for (int t = 0; t < Depth + 2; t++) begin
            if (rsp_valid !== 1'b0) stale++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (stale != 0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL no_stale: got stale=%0d busy=%b rdy=%b expected 0 0 1", stale, busy, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b1; req_addr = 4'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== (Sweep ? 36'h0 : 36'h0_ABCD_1234)) begin
            errors++;
            $display("[TB] FAIL contents_after_reset: got vld=%b data=%h expected vld=1 data=%h",
                     rsp_valid, rsp_rdata, Sweep ? 36'h0 : 36'h0_ABCD_1234);
        end
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] start, sweep=%0d", Sweep);
        test_reset();
        test_write_read();
        test_streaming();
        test_backpressure();
        test_write_read();
        test_reset_mid_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
